// File: rtl/vga.sv
// vga: VGA display controller with an internal frame buffer.
// Host writes {red, green, blue} pixels by linear address y*H_VISIBLE_AREA + x.
// Free-running h/v counters scan the buffer. Pixel data and both syncs are
// registered, so all outputs lag the counters by one clock and stay aligned.
// Ports:
//   clk          pixel clock, rising edge
//   reset        synchronous, active-low
//   write_enable frame-buffer write strobe
//   write_addr   linear write address; addresses >= MEM_SIZE are ignored
//   pixel_in     write data {red, green, blue}
//   pixel_out    current pixel, zero during blanking
//   h_sync       horizontal sync, active low
//   v_sync       vertical sync, active low
module vga #(
  parameter int unsigned RED_WIDTH      = 4,
  parameter int unsigned GREEN_WIDTH    = 4,
  parameter int unsigned BLUE_WIDTH     = 4,
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned H_FRONT_PORCH  = 16,
  parameter int unsigned H_SYNC_PULSE   = 96,
  parameter int unsigned H_BACK_PORCH   = 48,
  parameter int unsigned V_VISIBLE_AREA = 480,
  parameter int unsigned V_FRONT_PORCH  = 10,
  parameter int unsigned V_SYNC_PULSE   = 2,
  parameter int unsigned V_BACK_PORCH   = 33
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          write_enable,
  input  logic [31:0]                                   write_addr,
  input  logic [RED_WIDTH+GREEN_WIDTH+BLUE_WIDTH-1:0]   pixel_in,
  output logic [RED_WIDTH+GREEN_WIDTH+BLUE_WIDTH-1:0]   pixel_out,
  output logic                                          h_sync,
  output logic                                          v_sync
);

  localparam int unsigned PW       = RED_WIDTH + GREEN_WIDTH + BLUE_WIDTH;
  localparam int unsigned H_TOTAL  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int unsigned V_TOTAL  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int unsigned MEM_SIZE = H_VISIBLE_AREA * V_VISIBLE_AREA;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned AW       = $clog2(MEM_SIZE);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE_AREA);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE_AREA);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE - 1);

  logic [PW-1:0] mem_q [MEM_SIZE];

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [AW-1:0] rd_addr_c;
  logic [PW-1:0] rd_data_c;
  logic          visible_c;

  // Frame buffer write port; independent of reset, contents never cleared.
  always_ff @(posedge clk) begin
    if (write_enable && (write_addr < 32'(MEM_SIZE))) begin
      mem_q[AW'(write_addr)] <= pixel_in;
    end
  end

  // Asynchronous read; the registered output makes a same-cycle write read-first.
  assign rd_addr_c = AW'(AW'(v_q) * AW'(H_VISIBLE_AREA) + AW'(h_q));
  assign rd_data_c = mem_q[rd_addr_c];
  assign visible_c = (h_q < H_VIS_END) && (v_q < V_VIS_END);

  // Next-state for counters and outputs.
  always_comb begin
    h_d     = h_q + HW'(1);
    v_d     = v_q;
    pixel_d = '0;
    hs_d    = 1'b1;
    vs_d    = 1'b1;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
    if (visible_c) begin
      pixel_d = rd_data_c;
    end
    if ((h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST)) begin
      hs_d = 1'b0;
    end
    if ((v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST)) begin
      vs_d = 1'b0;
    end
  end

  // Scan state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      pixel_q <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      pixel_q <= pixel_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign pixel_out = pixel_q;
  assign h_sync    = hs_q;
  assign v_sync    = vs_q;

endmodule

// File: tb/tb_vga.sv
// tb_vga: randomized self-checking bench for vga in a 50x50 (61x61 total) setup.
// The reference model tracks a linear scan position and an array copy of the
// frame buffer; expected outputs follow from the position's x/y segments.
module tb_vga;

  localparam int unsigned VIS   = 50;
  localparam int unsigned FP    = 2;
  localparam int unsigned SYNC  = 4;
  localparam int unsigned BP    = 5;
  localparam int unsigned TOT   = VIS + FP + SYNC + BP;
  localparam int unsigned FRAME = TOT * TOT;
  localparam int unsigned MSIZE = VIS * VIS;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [11:0] pixel_in;
  logic [11:0] pixel_out;
  logic        h_sync;
  logic        v_sync;

  vga #(
    .RED_WIDTH(4), .GREEN_WIDTH(4), .BLUE_WIDTH(4),
    .H_VISIBLE_AREA(VIS), .H_FRONT_PORCH(FP), .H_SYNC_PULSE(SYNC), .H_BACK_PORCH(BP),
    .V_VISIBLE_AREA(VIS), .V_FRONT_PORCH(FP), .V_SYNC_PULSE(SYNC), .V_BACK_PORCH(BP)
  ) u_dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
    .pixel_in(pixel_in), .pixel_out(pixel_out), .h_sync(h_sync), .v_sync(v_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [11:0] mem_m [MSIZE];
  int          pos_m = 0;
  logic [11:0] exp_pix;
  logic        exp_hs;
  logic        exp_vs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic tick(input logic rst_n, input logic we, input logic [31:0] addr,
                      input logic [11:0] data);
    int x, y;
    reset        = rst_n;
    write_enable = we;
    write_addr   = addr;
    pixel_in     = data;
    @(posedge clk);
    if (!rst_n) begin
      exp_pix = '0;
      exp_hs  = 1'b1;
      exp_vs  = 1'b1;
      pos_m   = 0;
    end else begin
      x       = pos_m % TOT;
      y       = pos_m / TOT;
      exp_pix = (x < VIS && y < VIS) ? mem_m[y * VIS + x] : 12'h000;
      exp_hs  = !(x >= VIS + FP && x < VIS + FP + SYNC);
      exp_vs  = !(y >= VIS + FP && y < VIS + FP + SYNC);
      pos_m   = (pos_m + 1) % FRAME;
    end
    if (we && addr < MSIZE) mem_m[addr] = data;
    #1;
    check("pixel_out", 32'(pixel_out), 32'(exp_pix));
    check("h_sync", 32'(h_sync), 32'(exp_hs));
    check("v_sync", 32'(v_sync), 32'(exp_vs));
  endtask

  int hs_low, hs_first, vs_low, vs_first;
  logic [11:0] patt;

  initial begin
    reset = 1'b0; write_enable = 1'b0; write_addr = '0; pixel_in = '0;

    // Reset state, then fill the buffer while reset is held.
    tick(1'b0, 1'b0, 32'd0, 12'h000);
    for (int i = 0; i < VIS; i++) begin
      for (int j = 0; j < VIS; j++) begin
        patt = {4'(i >> 2), 4'(j >> 2), 1'(i & j & 1), 3'b000};
        tick(1'b0, 1'b1, 32'(i * VIS + j), patt);
      end
    end

    // First frame after release: pattern, h/v sync placement and width.
    hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1;
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b1, 1'b0, 32'd0, 12'h000);
      if (k == TOT + 1) check("pix_x1y1", 32'(pixel_out), 32'h008);
      if (k < TOT && !h_sync) begin
        if (hs_first < 0) hs_first = k;
        hs_low++;
      end
      if (!v_sync) begin
        if (vs_first < 0) vs_first = k;
        vs_low++;
      end
    end
    check("hs_low_len", 32'(hs_low), 32'(SYNC));
    check("hs_start", 32'(hs_first), 32'(VIS + FP));
    check("vs_low_len", 32'(vs_low), 32'(SYNC * TOT));
    check("vs_start", 32'(vs_first), 32'((VIS + FP) * TOT));

    // Out-of-range write, then a frame of random writes (some out of range).
    tick(1'b1, 1'b1, 32'd2500, 12'hFFF);
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, 12'hFFF);
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, MSIZE + 100)),
           12'($urandom));
    end

    // Write addr 0 and confirm the next frame's first pixel.
    tick(1'b1, 1'b1, 32'd0, 12'hABC);
    while (pos_m != 0) tick(1'b1, 1'b0, 32'd0, 12'h000);
    tick(1'b1, 1'b0, 32'd0, 12'h000);
    check("first_pix_abc", 32'(pixel_out), 32'hABC);

    // Mid-frame reset at line 20, pixel 30; then a full frame from (0,0).
    while (pos_m != 20 * TOT + 30) tick(1'b1, 1'b0, 32'd0, 12'h000);
    tick(1'b0, 1'b0, 32'd0, 12'h000);
    check("rst_mid_hs", 32'(h_sync), 32'd1);
    check("rst_mid_vs", 32'(v_sync), 32'd1);
    tick(1'b1, 1'b0, 32'd0, 12'h000);
    check("rst_mid_first", 32'(pixel_out), 32'hABC);
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b1, 1'($urandom_range(0, 3) == 0), 32'($urandom_range(0, MSIZE + 50)),
           12'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
